vga_ctrl: RTL and testbench
===========================

Name: vga_ctrl

Overview:
- VGA timing generator and pixel fetcher for the display path, 640x480@60 Hz at a 25 MHz pixel clock.
- Owns the H/V counters and drives pix_x/pix_y to the combinational screen generators (win/lose/game display).
- Samples their 16-bit RGB565 pix_data and outputs registered rgb plus hsync/vsync to the VGA connector.
- Sits between the screen generators and the board pins.

Parameters:
H_SYNC, 96, horizontal sync pulse width in pixels
H_BACK, 48, horizontal back porch
H_VALID, 640, active pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync pulse width in lines
V_BACK, 33, vertical back porch
V_VALID, 480, active lines
V_FRONT, 10, vertical front porch
SYNC_POL, 0, sync pulse level (0 = active-low)

Ports:
vga_clk  in  1  pixel clock, 25 MHz
sys_rst  in  1  synchronous, active-high reset
pix_data  in  16  RGB565 from the screen generator, combinational in pix_x/pix_y
pix_x  out  10  active-region column 0..639, 10'h3FF outside active
pix_y  out  10  active-region row 0..479, 10'h3FF outside active
pix_data_req  out  1  high while (cnt_h, cnt_v) is inside the active region
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
rgb  out  16  registered pixel to the pins, 0 outside active
rgb_valid  out  1  registered active-video flag
frame_start  out  1  one-cycle pulse, registered, marking position (0,0)

Behaviour:
- Interface decision: one clock, vga_clk; reset sys_rst is synchronous and active-high. Every flop is reset only on a vga_clk edge with sys_rst=1.
- Derived values:
  - H_TOTAL = sum of the H parameters = 800; V_TOTAL = 525.
  - H_ACT = H_SYNC + H_BACK = 144; V_ACT = V_SYNC + V_BACK = 35.
  - H_TOTAL and V_TOTAL must be ≤ 1024.
- cnt_h (10 b):
  - Increments every cycle.
  - At H_TOTAL-1 it wraps to 0.
- cnt_v (10 b):
  - Increments only when cnt_h == H_TOTAL-1.
  - When cnt_v == V_TOTAL-1 and cnt_h == H_TOTAL-1, both wrap to 0 on the same edge.
- Active region: H_ACT ≤ cnt_h < H_ACT+H_VALID AND V_ACT ≤ cnt_v < V_ACT+V_VALID.
- Fetch stage (combinational from counters):
  - pix_data_req = active.
  - pix_x = active ? cnt_h - H_ACT : 10'h3FF.
  - pix_y = active ? cnt_v - V_ACT : 10'h3FF.
- Output stage: all registered, latency exactly 1 cycle from counter position p. In cycle t+1 the outputs reflect p(t):
  - rgb <= active ? pix_data : 16'h0000.
  - rgb_valid <= active.
  - hsync <= (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL.
  - vsync <= (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL.
  - frame_start <= (cnt_h == 0 && cnt_v == 0).
- rgb, hsync and vsync therefore stay mutually aligned. pix_data is ignored whenever pix_data_req = 0.
- Reset values:
  - cnt_h = cnt_v = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
  - rgb = 0, rgb_valid = 0, frame_start = 0.
  - pix_x/pix_y follow the counters, so they read 10'h3FF during reset.
- First cycle after reset release: outputs reflect position (0,0), so hsync and vsync go active and frame_start = 1.
- Reset mid-frame: the counters restart at (0,0) on the next edge with no partial-line completion. The next frame_start pulses one cycle after release.
- Line wrap: position (H_ACT+H_VALID-1, y) is pixel 639. The next position goes inactive, and rgb drops to 0 one cycle later.
- Frame wrap: the last active pixel is (783, 514). Line 524 is front porch.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants;
  - derived H_TOTAL/V_TOTAL/H_ACT/V_ACT;
  - RGB565 colour constants RED 16'hF800, WHITE 16'hFFFF, BLACK 16'h0000, shared with the screen generators;
  - PIX_INVALID = 10'h3FF.
- One sub-module, vga_timing_cnt: the H/V counter pair with wrap logic, exporting cnt_h/cnt_v. vga_ctrl adds the decode and output register stage.

Test Plan:
- Reset: hold sys_rst 3 cycles → hsync=vsync=1, rgb=0, rgb_valid=0, frame_start=0, pix_x=pix_y=10'h3FF, pix_data_req=0.
- Horizontal timing: after release, measure hsync → low for exactly 96 cycles, period 800 cycles; rgb_valid high for 640 consecutive cycles per active line.
- First pixel: at cnt_h=144, cnt_v=35 → pix_data_req=1, pix_x=0, pix_y=0. Bench drives pix_data=16'hF800 → next cycle rgb=16'hF800, rgb_valid=1.
- Line end: at cnt_h=783 → pix_x=639. Next cycle pix_x=10'h3FF and req=0; bench drives pix_data=16'hFFFF → following cycle rgb=0, rgb_valid=0.
- Vertical/frame: vsync low for exactly 1600 cycles per frame; frame_start pulses once every 420000 cycles; pix_y reaches 479 then 10'h3FF.
- Mid-frame reset: assert sys_rst 1 cycle at cnt_v=200 → next cycle all outputs at reset values; frame_start=1 on the first cycle after release; next hsync low pulse starts at that same cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, derived totals, RGB565 colours.
// Imported by the controller, its counter block and the screen generators.
package vga_pkg;

  localparam int COORD_W = 32'd10;
  localparam int COLOR_W = 32'd16;

  localparam int H_SYNC  = 32'd96;
  localparam int H_BACK  = 32'd48;
  localparam int H_VALID = 32'd640;
  localparam int H_FRONT = 32'd16;
  localparam int V_SYNC  = 32'd2;
  localparam int V_BACK  = 32'd33;
  localparam int V_VALID = 32'd480;
  localparam int V_FRONT = 32'd10;
  localparam logic SYNC_POL = 1'b0;

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK;
  localparam int V_ACT   = V_SYNC + V_BACK;

  localparam logic [COLOR_W-1:0] RED   = 16'hF800;
  localparam logic [COLOR_W-1:0] WHITE = 16'hFFFF;
  localparam logic [COLOR_W-1:0] BLACK = 16'h0000;

  localparam logic [COORD_W-1:0] PIX_INVALID = 10'h3FF;

endpackage

// File: rtl/vga_if.sv
// Display-path bus: pixel fetch towards the screen generators plus the VGA pin outputs.
interface vga_if;
  import vga_pkg::*;

  logic [COLOR_W-1:0] pix_data;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_data_req;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] rgb;
  logic               rgb_valid;
  logic               frame_start;

  modport master (
    input  pix_data,
    output pix_x, pix_y, pix_data_req,
    output hsync, vsync, rgb, rgb_valid, frame_start
  );

  modport slave (
    output pix_data,
    input  pix_x, pix_y, pix_data_req,
    input  hsync, vsync, rgb, rgb_valid, frame_start
  );
endinterface

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical position counters; both wrap together at the end of a frame.
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int H_LEN = vga_pkg::H_TOTAL,
  parameter int V_LEN = vga_pkg::V_TOTAL
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] cnt_h,
  output logic [COORD_W-1:0] cnt_v
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_LEN - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_LEN - 1);

  logic [COORD_W-1:0] cnt_h_r;
  logic [COORD_W-1:0] cnt_v_r;
  logic               h_end_s;
  logic               v_end_s;

  assign h_end_s = (cnt_h_r == H_LAST);
  assign v_end_s = (cnt_v_r == V_LAST);

  // Pixel counter every cycle; line counter advances on the last pixel of a line
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_h_r <= 10'd0;
      cnt_v_r <= 10'd0;
    end else if (h_end_s) begin
      cnt_h_r <= 10'd0;
      if (v_end_s) begin
        cnt_v_r <= 10'd0;
      end else begin
        cnt_v_r <= cnt_v_r + 10'd1;
      end
    end else begin
      cnt_h_r <= cnt_h_r + 10'd1;
    end
  end

  assign cnt_h = cnt_h_r;
  assign cnt_v = cnt_v_r;

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator and pixel fetcher: decodes the counter position into fetch
// coordinates and registers rgb/sync/valid/frame_start one cycle behind that position.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BACK   = vga_pkg::H_BACK,
  parameter int   H_VALID  = vga_pkg::H_VALID,
  parameter int   H_FRONT  = vga_pkg::H_FRONT,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BACK   = vga_pkg::V_BACK,
  parameter int   V_VALID  = vga_pkg::V_VALID,
  parameter int   V_FRONT  = vga_pkg::V_FRONT,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic  vga_clk,
  input  logic  sys_rst,
  vga_if.master bus
);

  localparam int H_TOT = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [COORD_W-1:0] H_STA_W  = COORD_W'(H_SYNC + H_BACK);
  localparam logic [COORD_W-1:0] V_STA_W  = COORD_W'(V_SYNC + V_BACK);
  localparam logic [COORD_W-1:0] H_END_W  = COORD_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [COORD_W-1:0] V_END_W  = COORD_W'(V_SYNC + V_BACK + V_VALID);
  localparam logic [COORD_W-1:0] H_SYNC_W = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_W = COORD_W'(V_SYNC);

  logic [COORD_W-1:0] cnt_h_s;
  logic [COORD_W-1:0] cnt_v_s;
  logic               active_s;
  logic [COORD_W-1:0] pix_x_s;
  logic [COORD_W-1:0] pix_y_s;

  logic [COLOR_W-1:0] rgb_r;
  logic               rgb_valid_r;
  logic               hsync_r;
  logic               vsync_r;
  logic               frame_start_r;

  vga_timing_cnt #(
    .H_LEN (H_TOT),
    .V_LEN (V_TOT)
  ) u_cnt (
    .clk   (vga_clk),
    .rst   (sys_rst),
    .cnt_h (cnt_h_s),
    .cnt_v (cnt_v_s)
  );

  // Active-region decode and fetch coordinates for the screen generators
  always_comb begin
    active_s = (cnt_h_s >= H_STA_W) && (cnt_h_s < H_END_W) &&
               (cnt_v_s >= V_STA_W) && (cnt_v_s < V_END_W);
    if (active_s) begin
      pix_x_s = cnt_h_s - H_STA_W;
      pix_y_s = cnt_v_s - V_STA_W;
    end else begin
      pix_x_s = PIX_INVALID;
      pix_y_s = PIX_INVALID;
    end
  end

  // Output stage: everything lags the counter position by exactly one cycle
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      rgb_r         <= BLACK;
      rgb_valid_r   <= 1'b0;
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      frame_start_r <= 1'b0;
    end else begin
      if (active_s) begin
        rgb_r <= bus.pix_data;
      end else begin
        rgb_r <= BLACK;
      end
      rgb_valid_r   <= active_s;
      hsync_r       <= (cnt_h_s < H_SYNC_W) ? SYNC_POL : ~SYNC_POL;
      vsync_r       <= (cnt_v_s < V_SYNC_W) ? SYNC_POL : ~SYNC_POL;
      frame_start_r <= (cnt_h_s == 10'd0) && (cnt_v_s == 10'd0);
    end
  end

  assign bus.pix_x        = pix_x_s;
  assign bus.pix_y        = pix_y_s;
  assign bus.pix_data_req = active_s;
  assign bus.rgb          = rgb_r;
  assign bus.rgb_valid    = rgb_valid_r;
  assign bus.hsync        = hsync_r;
  assign bus.vsync        = vsync_r;
  assign bus.frame_start  = frame_start_r;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: frame-index model checked every cycle plus hand-computed checkpoints.
// Vertical timing is shortened (2/3/8/2 lines) so whole frames fit in a short run.
module tb_vga_ctrl;
  import vga_pkg::*;

  localparam int H_TOT = 800;
  localparam int H_STA = 144;
  localparam int H_END = 784;
  localparam int V_STA = 5;
  localparam int V_END = 13;
  localparam int V_TOT = 15;
  localparam int FRAME = H_TOT * V_TOT;   // 12000

  logic clk;
  logic sys_rst;
  vga_if bus();

  vga_ctrl #(
    .V_SYNC  (2),
    .V_BACK  (3),
    .V_VALID (8),
    .V_FRONT (2)
  ) dut (
    .vga_clk (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // Screen generator model: a coordinate-dependent colour, red at the origin, white when invalid
  function automatic logic [15:0] gen(input logic [9:0] x, input logic [9:0] y);
    if (x == PIX_INVALID || y == PIX_INVALID) return WHITE;
    if (x == 10'd0 && y == 10'd0) return RED;
    return {x[4:0], y[5:0], x[9:5]};
  endfunction

  assign bus.pix_data = gen(bus.pix_x, bus.pix_y);

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: number of non-reset edges since the last reset edge
  int   k = 0;
  logic out_rst = 1'b1;
  logic model_on = 1'b0;

  always @(posedge clk) begin
    if (sys_rst) begin
      k        <= 0;
      out_rst  <= 1'b1;
      model_on <= 1'b1;
    end else begin
      k       <= k + 1;
      out_rst <= 1'b0;
    end
  end

  function automatic logic act_at(input int p);
    int h = p % H_TOT;
    int v = p / H_TOT;
    return (h >= H_STA) && (h < H_END) && (v >= V_STA) && (v < V_END);
  endfunction

  int          p, q;
  logic [9:0]  ex_x, ex_y, qx, qy;
  logic [15:0] ex_rgb;
  logic        ex_val, ex_hs, ex_vs, ex_fs;

  // Per-cycle compare: current position drives fetch outputs, previous position drives registers
  always @(negedge clk) begin
    if (model_on) begin
      p = k % FRAME;
      q = (k + FRAME - 1) % FRAME;
      if (act_at(p)) begin
        ex_x = 10'(p % H_TOT - H_STA);
        ex_y = 10'(p / H_TOT - V_STA);
      end else begin
        ex_x = PIX_INVALID;
        ex_y = PIX_INVALID;
      end
      check("pix_x", 16'(bus.pix_x), 16'(ex_x));
      check("pix_y", 16'(bus.pix_y), 16'(ex_y));
      check("pix_data_req", 16'(bus.pix_data_req), 16'(act_at(p)));
      if (out_rst) begin
        ex_rgb = 16'h0000; ex_val = 1'b0; ex_hs = 1'b1; ex_vs = 1'b1; ex_fs = 1'b0;
      end else begin
        ex_val = act_at(q);
        qx     = 10'(q % H_TOT - H_STA);
        qy     = 10'(q / H_TOT - V_STA);
        ex_rgb = ex_val ? gen(qx, qy) : 16'h0000;
        ex_hs  = !((q % H_TOT) < 96);
        ex_vs  = !((q / H_TOT) < 2);
        ex_fs  = (q == 0);
      end
      check("rgb", bus.rgb, ex_rgb);
      check("rgb_valid", 16'(bus.rgb_valid), 16'(ex_val));
      check("hsync", 16'(bus.hsync), 16'(ex_hs));
      check("vsync", 16'(bus.vsync), 16'(ex_vs));
      check("frame_start", 16'(bus.frame_start), 16'(ex_fs));
    end
  end

  task automatic wait_k(input int target);
    int guard = 0;
    while (k != target && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    if (k != target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_k: k=%0d, expected %0d", k, target);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hsync"}, 16'(bus.hsync), 16'h0001);
    check({tag, "_vsync"}, 16'(bus.vsync), 16'h0001);
    check({tag, "_rgb"}, bus.rgb, 16'h0000);
    check({tag, "_rgb_valid"}, 16'(bus.rgb_valid), 16'h0000);
    check({tag, "_frame_start"}, 16'(bus.frame_start), 16'h0000);
    check({tag, "_pix_x"}, 16'(bus.pix_x), 16'h03FF);
    check({tag, "_pix_y"}, 16'(bus.pix_y), 16'h03FF);
    check({tag, "_req"}, 16'(bus.pix_data_req), 16'h0000);
  endtask

  int hs_low = 0, vs_low = 0, fs_cnt = 0, val_cnt = 0;

  initial begin
    sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    sys_rst = 1'b0;
    wait_k(1);
    check("first_fs", 16'(bus.frame_start), 16'h0001);
    check("first_hsync", 16'(bus.hsync), 16'h0000);
    check("first_vsync", 16'(bus.vsync), 16'h0000);

    // One full frame of measurements plus fixed checkpoints (k = position after k edges)
    for (int i = 0; i < FRAME; i++) begin
      if (k <= 800 && bus.hsync == 1'b0) hs_low++;
      if (bus.vsync == 1'b0) vs_low++;
      if (bus.frame_start == 1'b1) fs_cnt++;
      if (k > 4000 && k <= 4800 && bus.rgb_valid == 1'b1) val_cnt++;
      if (k == 4144) begin
        check("first_pix_req", 16'(bus.pix_data_req), 16'h0001);
        check("first_pix_x", 16'(bus.pix_x), 16'h0000);
        check("first_pix_y", 16'(bus.pix_y), 16'h0000);
      end
      if (k == 4145) begin
        check("first_rgb", bus.rgb, 16'hF800);
        check("first_rgb_valid", 16'(bus.rgb_valid), 16'h0001);
      end
      if (k == 4783) check("line_end_x", 16'(bus.pix_x), 16'd639);
      if (k == 4784) begin
        check("after_end_x", 16'(bus.pix_x), 16'h03FF);
        check("after_end_req", 16'(bus.pix_data_req), 16'h0000);
      end
      if (k == 4785) begin
        check("after_end_rgb", bus.rgb, 16'h0000);
        check("after_end_valid", 16'(bus.rgb_valid), 16'h0000);
      end
      if (k == 9744) check("last_row_y", 16'(bus.pix_y), 16'd7);
      if (k == 10544) check("below_last_y", 16'(bus.pix_y), 16'h03FF);
      @(negedge clk);
    end
    check("next_frame_fs", 16'(bus.frame_start), 16'h0001);
    check("hsync_low_width", 16'(hs_low), 16'd96);
    check("vsync_low_width", 16'(vs_low), 16'd1600);
    check("frame_start_count", 16'(fs_cnt), 16'd1);
    check("line_valid_count", 16'(val_cnt), 16'd640);

    // Mid-frame reset inside an active line of the second frame
    wait_k(18700);
    check("pre_reset_valid", 16'(bus.rgb_valid), 16'h0001);
    sys_rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    sys_rst = 1'b0;
    @(negedge clk);
    check("post_reset_fs", 16'(bus.frame_start), 16'h0001);
    check("post_reset_hsync", 16'(bus.hsync), 16'h0000);
    wait_k(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
